acltx_pybuf: RTL

Two-bank ACL-U transmit payload buffer feeding the baseband payload encoder. It consumes the ARQ payload-selection decisions (send new, resend old, send zero-length continuation after flush) and holds the in-flight payload until it is acknowledged, so retransmissions replay identical bytes. Host-side packet writes fill the free bank while the other bank is transmitted.

---
 rtl/acltx_pkg.sv | 12 +
 rtl/pybuf_ram.sv | 19 +
 rtl/acltx_pybuf.sv | 139 +++++++++++++
 3 files changed

// File: rtl/acltx_pkg.sv
// acltx_pkg: shared types and sizing for the ACL-U transmit payload buffer
package acltx_pkg;
  localparam int BANK_BYTES = 1024;
  localparam int AW = 10;
  // one extra bit so a completely full bank reports its true length of BANK_BYTES
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY, B_INFLIGHT} bank_st_e;
  typedef enum logic [1:0] {SEL_NONE, SEL_OLD, SEL_NEW, SEL_ZERO} py_sel_e;
  function automatic py_sel_e py_sel(input logic zero, input logic nw, input logic old);
    return zero ? SEL_ZERO : nw ? SEL_NEW : old ? SEL_OLD : SEL_NONE;
  endfunction
endpackage

// File: rtl/pybuf_ram.sv
// pybuf_ram: two-bank simple dual-port byte RAM with registered read, address {bank, offset}
module pybuf_ram
  import acltx_pkg::*;
(
  input  logic          clk_6M,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2*BANK_BYTES];
  // host write port and synchronous encoder read port
  always_ff @(posedge clk_6M) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/acltx_pybuf.sv
// acltx_pybuf: two-bank ACL-U TX payload buffer holding the in-flight payload until ACKed
module acltx_pybuf
  import acltx_pkg::*;
(
  input  logic          clk_6M,
  input  logic          rstz,
  input  logic          conn_new_p,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          wr_commit,
  output logic          wr_ready,
  output logic          wr_err,
  input  logic          py_start_p,
  input  logic          sendnewpy,
  input  logic          sendoldpy,
  input  logic          send0cpy,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [LW-1:0] py_len,
  output logic          tx_has_data,
  output logic          flush_done_p
);
  bank_st_e      st_q [2];
  bank_st_e      st_d [2];
  logic [LW-1:0] len_q [2];
  logic [LW-1:0] len_d [2];
  logic [LW-1:0] wr_cnt_q, wr_cnt_d, rd_ptr_q, rd_ptr_d, py_len_d;
  logic          oldest_q, oldest_d, tx_d, flush_d, wr_err_d, rd_valid_d, rd_ok_q, rd_ok_d;
  logic          fb, has_fill, fly, has_fly, wr_ok, r0, r1, ro;
  py_sel_e       sel;
  logic          ram_re;
  logic [AW:0]   ram_waddr, ram_raddr;
  logic [7:0]    ram_q;
  // a partially filled bank keeps priority so its bytes are never abandoned
  assign has_fill  = st_q[0] inside {B_FREE, B_FILLING} || st_q[1] inside {B_FREE, B_FILLING};
  assign fb        = (st_q[0] == B_FILLING) ? 1'b0 : (st_q[1] == B_FILLING) ? 1'b1 : (st_q[0] != B_FREE);
  assign fly       = st_q[1] == B_INFLIGHT;
  assign has_fly   = fly || st_q[0] == B_INFLIGHT;
  assign sel       = py_sel(send0cpy, sendnewpy, sendoldpy);
  assign wr_ok     = wr_en && has_fill && wr_cnt_q != LW'(BANK_BYTES);
  assign ram_waddr = {fb, wr_cnt_q[AW-1:0]};
  assign ram_re    = rd_en && !py_start_p;
  assign ram_raddr = {fly, rd_ptr_q[AW-1:0]};
  pybuf_ram u_ram (
    .clk_6M (clk_6M),
    .we     (wr_ok),
    .waddr  (ram_waddr),
    .wdata  (wr_data),
    .re     (ram_re),
    .raddr  (ram_raddr),
    .rdata  (ram_q)
  );
  // state register: bank states, lengths, counters and registered outputs
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      st_q         <= '{B_FREE, B_FREE};
      len_q        <= '{default: '0};
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      oldest_q     <= 1'b0;
      py_len       <= '0;
      tx_has_data  <= 1'b0;
      flush_done_p <= 1'b0;
      wr_err       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      st_q         <= st_d;
      len_q        <= len_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      oldest_q     <= oldest_d;
      py_len       <= py_len_d;
      tx_has_data  <= tx_d;
      flush_done_p <= flush_d;
      wr_err       <= wr_err_d;
      rd_valid     <= rd_valid_d;
      rd_ok_q      <= rd_ok_d;
    end
  end
  // next state: write, then commit, then payload selection on the post-commit banks
  always_comb begin
    st_d       = st_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q + LW'(wr_ok);
    rd_ptr_d   = rd_ptr_q;
    oldest_d   = oldest_q;
    py_len_d   = py_len;
    tx_d       = tx_has_data;
    flush_d    = 1'b0;
    wr_err_d   = wr_en && !wr_ok;
    rd_valid_d = rd_en;
    rd_ok_d    = 1'b0;
    if (wr_ok) st_d[fb] = B_FILLING;
    if (wr_commit && has_fill && st_d[fb] == B_FILLING) begin
      st_d[fb]  = B_READY;
      len_d[fb] = wr_cnt_d;
      wr_cnt_d  = '0;
      oldest_d  = (st_q[!fb] == B_READY) ? !fb : fb;
    end
    r0 = st_d[0] == B_READY;
    r1 = st_d[1] == B_READY;
    ro = (r0 && r1) ? oldest_d : r1;
    if (py_start_p) begin
      rd_ptr_d = '0;
      py_len_d = '0;
      if ((sel == SEL_ZERO || sel == SEL_NEW) && has_fly) st_d[fly] = B_FREE;
      flush_d = sel == SEL_ZERO && has_fly;
      if (sel == SEL_NEW && (r0 || r1)) begin
        st_d[ro] = B_INFLIGHT;
        py_len_d = len_d[ro];
      end
      if (sel == SEL_OLD && has_fly) py_len_d = len_q[fly];
      tx_d = py_len_d != '0;
    end else if (rd_en) begin
      rd_ok_d  = rd_ptr_q < py_len;
      rd_ptr_d = rd_ptr_q + LW'(rd_ok_d);
    end
    if (conn_new_p) begin
      st_d       = '{B_FREE, B_FREE};
      len_d      = '{default: '0};
      wr_cnt_d   = '0;
      rd_ptr_d   = '0;
      oldest_d   = 1'b0;
      py_len_d   = '0;
      tx_d       = 1'b0;
      flush_d    = 1'b0;
      wr_err_d   = 1'b0;
      rd_valid_d = 1'b0;
      rd_ok_d    = 1'b0;
    end
  end
  // outputs: host readiness and zero-masked read data past the payload end
  always_comb begin
    wr_ready = has_fill;
    rd_data  = (rd_valid && rd_ok_q) ? ram_q : 8'h00;
  end
endmodule
